seq_stage_classifier: RTL and testbench
=======================================

Name: seq_stage_classifier

Overview:
- Time-multiplexed successor to the combinational stage evaluator.
- Walks a run-time-selectable number of Haar classifiers for one stage, one classifier at a time.
- Per classifier: fetches its 18 parameters from the cascade ROM and its 12 corner values from the integral-image buffer, evaluates the weighted feature, and accumulates the selected leaf word.
- Finishes by comparing the accumulated stage sum against the stage threshold. Sits between the cascade controller and the integral-image window buffer.

Parameters:
- DATA_WIDTH_8, 8, ROM word width, integral-image index width, classifier count width.
- DATA_WIDTH_12, 12, ROM address width.
- DATA_WIDTH_16, 16, integral-image value width (unsigned).
- NUM_PARAM_PER_CLASSIFIER, 18, ROM words per classifier.
- FEAT_WIDTH, 28, signed feature accumulator width.
- ACC_WIDTH, 16, signed stage-sum width.

Ports:
- clk_fpga  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- i_start  in  1  start pulse; accepted only in IDLE
- i_abort  in  1  synchronous abort; returns to IDLE with no result
- i_stage_base  in  DATA_WIDTH_12  ROM address of this stage's classifier 0, parameter 0
- i_num_classifiers  in  DATA_WIDTH_8  classifier count N, sampled on start
- o_rom_addr  out  DATA_WIDTH_12  cascade ROM read address
- i_rom_data  in  DATA_WIDTH_8  ROM data, valid 1 cycle after address
- o_ii_addr  out  DATA_WIDTH_8  integral-image index
- i_ii_data  in  DATA_WIDTH_16  integral-image value, valid 1 cycle after address
- o_busy  out  1  high from start acceptance until o_valid
- o_valid  out  1  1-cycle result strobe
- o_iscandidate  out  1  stage pass flag, valid with o_valid and held until next start
- o_haar_sum  out  ACC_WIDTH  final signed stage sum, held until next start

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0; counters and accumulators 0.
- ROM layout: parameter p of classifier c at i_stage_base + c*18 + p, in this order: A1,B1,C1,D1,W1,A2,B2,C2,D2,W2,A3,B3,C3,D3,W3,THR,LEFT,RIGHT. Stage threshold is at i_stage_base + N*18.
- Signedness: W, THR, LEFT, RIGHT and the stage threshold are two's-complement. Corner words are unsigned indices.
- States: IDLE -> FETCH_PARAM -> FETCH_II -> EVAL -> (next classifier: FETCH_PARAM | done: STAGE_THR) -> DONE -> IDLE.
- IDLE: on i_start, latch base and N, clear the sum, set o_busy and o_iscandidate=0. If N=0, go directly to STAGE_THR.
- FETCH_PARAM, 19 cycles: addresses issued on cycles 0..17; data captured on cycles 1..18.
- FETCH_II, 13 cycles: corners A1..D3 issued on cycles 0..11; data captured on cycles 1..12. Reads are always performed, even when a weight is 0.
- EVAL, 1 cycle:
  - rect_i = A-B-C+D, zero-extended to FEAT_WIDTH.
  - feature = sum of W_i*rect_i.
  - If feature < sign-extended THR, sum += LEFT; otherwise sum += RIGHT.
  - Increment classifier index.
  - Each classifier takes exactly 33 cycles.
- STAGE_THR, 2 cycles: issue the threshold address, then capture it and compute iscandidate = (sum > sign-extended threshold).
- DONE, 1 cycle: o_valid=1, o_busy=0, outputs updated. Then go to IDLE.
- Latency: start accepted at edge 0 -> o_valid high in cycle N*33+3.
- o_rom_addr and o_ii_addr hold their last value when not issuing.
- i_start while busy: ignored.
- i_abort: takes priority over every state transition. In any non-IDLE state it goes to IDLE next cycle, o_busy=0, no o_valid, o_haar_sum and o_iscandidate unchanged. In IDLE it has no effect. i_abort and i_start together in IDLE: abort wins, start is not accepted.
- Arithmetic: no saturation. ACC_WIDTH=16 covers 255 leaves of ±128.

Decomposition:
- Shared package: parameter-offset constants (OFF_A1..OFF_RIGHT), NUM_PARAM_PER_CLASSIFIER, the state enum, and the per-classifier cycle count 33.
- One sub-module, haar_feature_eval (combinational): 12 corners + 3 weights + THR + LEFT + RIGHT -> signed leaf value. It is reused by later multi-lane variants.

Test Plan:
- N=1, rect1 corners A=100,B=40,C=30,D=10, W1=2, W2=W3=0, THR=50, RIGHT=5, LEFT=-3, stage thr=4 -> feature 80, sum=5, o_iscandidate=1, o_valid in cycle 36.
- Same as above with THR=100 -> LEFT chosen, o_haar_sum=-3 (0xFFFD), o_iscandidate=0.
- N=0, stage thr=-1 -> exactly one ROM read at i_stage_base, o_haar_sum=0, o_iscandidate=1, o_valid in cycle 3.
- N=3, all leaves 127, stage thr=120 -> o_haar_sum=381, o_iscandidate=1, o_valid in cycle 102. A second i_start pulse at cycle 10 is ignored.
- N=2, i_abort at cycle 40 -> o_busy=0 in cycle 41, no o_valid, prior outputs unchanged. A new start then completes normally.
- reset_n low asynchronously mid-FETCH_II -> all outputs 0 immediately. After release, the block stays IDLE until the next i_start.

Source files
------------

// File: rtl/seq_stage_classifier_pkg.sv
// Shared constants, state encoding and small helpers for the time-multiplexed
// Haar stage classifier and its combinational feature evaluator.
package seq_stage_classifier_pkg;

  localparam int DATA_WIDTH_8             = 8;
  localparam int DATA_WIDTH_12            = 12;
  localparam int DATA_WIDTH_16            = 16;
  localparam int NUM_PARAM_PER_CLASSIFIER = 18;
  localparam int FEAT_WIDTH               = 28;
  localparam int ACC_WIDTH                = 16;
  localparam int NUM_RECTS                = 3;
  localparam int NUM_CORNERS              = 12;

  // Cycle budget of one classifier: parameter fetch + corner fetch + evaluate.
  localparam int FETCH_PARAM_CYCLES    = 19;
  localparam int FETCH_II_CYCLES       = 13;
  localparam int CYCLES_PER_CLASSIFIER = 33;

  // Parameter offsets inside one classifier's ROM record.
  localparam int OFF_A1 = 0,  OFF_B1 = 1,  OFF_C1 = 2,  OFF_D1 = 3,  OFF_W1 = 4;
  localparam int OFF_A2 = 5,  OFF_B2 = 6,  OFF_C2 = 7,  OFF_D2 = 8,  OFF_W2 = 9;
  localparam int OFF_A3 = 10, OFF_B3 = 11, OFF_C3 = 12, OFF_D3 = 13, OFF_W3 = 14;
  localparam int OFF_THR = 15, OFF_LEFT = 16, OFF_RIGHT = 17;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_PARAM,
    S_FETCH_II,
    S_EVAL,
    S_STAGE_THR,
    S_DONE
  } state_t;

  // Corner k (0..11, A1..D3) lives at record offset k + k/4, skipping each weight.
  function automatic logic [4:0] corner_off(input logic [3:0] k);
    return {1'b0, k} + {3'b000, k[3:2]};
  endfunction

  // Unsigned integral-image value widened into the signed feature domain.
  function automatic logic signed [FEAT_WIDTH-1:0] zext_corner(input logic [DATA_WIDTH_16-1:0] v);
    return {{(FEAT_WIDTH-DATA_WIDTH_16){1'b0}}, v};
  endfunction

  // Two's-complement ROM byte widened into the signed feature domain.
  function automatic logic signed [FEAT_WIDTH-1:0] sext_byte(input logic [DATA_WIDTH_8-1:0] v);
    return {{(FEAT_WIDTH-DATA_WIDTH_8){v[DATA_WIDTH_8-1]}}, v};
  endfunction

endpackage

// File: rtl/seq_stage_classifier_haar_eval.sv
// Combinational evaluation of one Haar classifier: three weighted rectangle
// sums compared against the classifier threshold select the left or right leaf.
module haar_feature_eval
  import seq_stage_classifier_pkg::*;
(
  input  logic [DATA_WIDTH_16-1:0] i_corner [NUM_CORNERS],
  input  logic [DATA_WIDTH_8-1:0]  i_weight [NUM_RECTS],
  input  logic [DATA_WIDTH_8-1:0]  i_thr,
  input  logic [DATA_WIDTH_8-1:0]  i_left,
  input  logic [DATA_WIDTH_8-1:0]  i_right,
  output logic [DATA_WIDTH_8-1:0]  o_leaf
);

  logic signed [FEAT_WIDTH-1:0] w_rect [NUM_RECTS];
  logic signed [FEAT_WIDTH-1:0] w_feature;
  logic signed [FEAT_WIDTH-1:0] w_thr_ext;

  // Rectangle sums A-B-C+D and their weighted total.
  always_comb begin
    // NOTE: give every always_comb target a value before any conditional/loop
    // update so no path leaves it unassigned (which would infer a latch).
    w_feature = '0;
    for (int r = 0; r < NUM_RECTS; r++) begin
      w_rect[r] = zext_corner(i_corner[4*r])   - zext_corner(i_corner[4*r+1])
                - zext_corner(i_corner[4*r+2]) + zext_corner(i_corner[4*r+3]);
      w_feature = w_feature + sext_byte(i_weight[r]) * w_rect[r];
    end
  end

  assign w_thr_ext = sext_byte(i_thr);
  assign o_leaf    = (w_feature < w_thr_ext) ? i_left : i_right;

endmodule

// File: rtl/seq_stage_classifier.sv
// Time-multiplexed stage evaluator: walks N classifiers one at a time, fetching
// parameters from the cascade ROM and corners from the integral-image buffer,
// accumulates leaf values and finally compares against the stage threshold.
module seq_stage_classifier
  import seq_stage_classifier_pkg::*;
(
  input  logic                     clk_fpga,
  input  logic                     reset_n,
  input  logic                     i_start,
  input  logic                     i_abort,
  input  logic [DATA_WIDTH_12-1:0] i_stage_base,
  input  logic [DATA_WIDTH_8-1:0]  i_num_classifiers,
  output logic [DATA_WIDTH_12-1:0] o_rom_addr,
  input  logic [DATA_WIDTH_8-1:0]  i_rom_data,
  output logic [DATA_WIDTH_8-1:0]  o_ii_addr,
  input  logic [DATA_WIDTH_16-1:0] i_ii_data,
  output logic                     o_busy,
  output logic                     o_valid,
  output logic                     o_iscandidate,
  output logic [ACC_WIDTH-1:0]     o_haar_sum
);

  state_t                         r_state;
  logic [4:0]                     r_cnt;
  logic [DATA_WIDTH_8-1:0]        r_cls_idx;
  logic [DATA_WIDTH_8-1:0]        r_num_cls;
  logic [DATA_WIDTH_12-1:0]       r_cls_base;
  logic signed [ACC_WIDTH-1:0]    r_sum;
  logic [DATA_WIDTH_8-1:0]        r_param  [NUM_PARAM_PER_CLASSIFIER];
  logic [DATA_WIDTH_16-1:0]       r_corner [NUM_CORNERS];

  logic [DATA_WIDTH_8-1:0]        w_weight [NUM_RECTS];
  logic [DATA_WIDTH_8-1:0]        w_leaf;
  logic signed [ACC_WIDTH-1:0]    w_leaf_ext;
  logic signed [ACC_WIDTH-1:0]    w_stage_thr_ext;
  logic [3:0]                     w_next_corner;
  logic [3:0]                     w_corner_idx;

  assign w_weight[0] = r_param[OFF_W1];
  assign w_weight[1] = r_param[OFF_W2];
  assign w_weight[2] = r_param[OFF_W3];

  haar_feature_eval u_eval (
    .i_corner (r_corner),
    .i_weight (w_weight),
    .i_thr    (r_param[OFF_THR]),
    .i_left   (r_param[OFF_LEFT]),
    .i_right  (r_param[OFF_RIGHT]),
    .o_leaf   (w_leaf)
  );

  assign w_leaf_ext      = {{(ACC_WIDTH-DATA_WIDTH_8){w_leaf[DATA_WIDTH_8-1]}}, w_leaf};
  assign w_stage_thr_ext = {{(ACC_WIDTH-DATA_WIDTH_8){i_rom_data[DATA_WIDTH_8-1]}}, i_rom_data};
  assign w_next_corner   = r_cnt[3:0] + 4'd1;
  assign w_corner_idx    = r_cnt[3:0] - 4'd1;

  // Sequencer: state, counters, accumulator, memory addresses and result outputs.
  always_ff @(posedge clk_fpga or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_cls_idx     <= '0;
      r_num_cls     <= '0;
      r_cls_base    <= '0;
      r_sum         <= '0;
      o_rom_addr    <= '0;
      o_ii_addr     <= '0;
      o_busy        <= 1'b0;
      o_valid       <= 1'b0;
      o_iscandidate <= 1'b0;
      o_haar_sum    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      o_valid <= 1'b0;
      if (i_abort && r_state != S_IDLE) begin
        r_state <= S_IDLE;
        o_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start && !i_abort) begin
              r_num_cls     <= i_num_classifiers;
              r_cls_base    <= i_stage_base;
              r_cls_idx     <= '0;
              r_sum         <= '0;
              r_cnt         <= '0;
              o_rom_addr    <= i_stage_base;
              o_busy        <= 1'b1;
              o_iscandidate <= 1'b0;
              r_state       <= (i_num_classifiers == '0) ? S_STAGE_THR : S_FETCH_PARAM;
            end
          end
          S_FETCH_PARAM: begin
            if (r_cnt < 5'(NUM_PARAM_PER_CLASSIFIER - 1))
              o_rom_addr <= r_cls_base + {7'd0, r_cnt} + 12'd1;
            if (r_cnt == 5'(FETCH_PARAM_CYCLES - 1)) begin
              r_cnt     <= '0;
              o_ii_addr <= r_param[OFF_A1];
              r_state   <= S_FETCH_II;
            end else begin
              r_cnt <= r_cnt + 5'd1;
            end
          end
          S_FETCH_II: begin
            if (r_cnt < 5'(NUM_CORNERS - 1))
              o_ii_addr <= r_param[corner_off(w_next_corner)];
            if (r_cnt == 5'(FETCH_II_CYCLES - 1)) begin
              r_cnt   <= '0;
              r_state <= S_EVAL;
            end else begin
              r_cnt <= r_cnt + 5'd1;
            end
          end
          S_EVAL: begin
            // The next record (or the stage threshold after the last one) follows directly.
            r_sum      <= r_sum + w_leaf_ext;
            r_cls_idx  <= r_cls_idx + 8'd1;
            r_cls_base <= r_cls_base + 12'(NUM_PARAM_PER_CLASSIFIER);
            o_rom_addr <= r_cls_base + 12'(NUM_PARAM_PER_CLASSIFIER);
            r_cnt      <= '0;
            r_state    <= (r_cls_idx + 8'd1 == r_num_cls) ? S_STAGE_THR : S_FETCH_PARAM;
          end
          S_STAGE_THR: begin
            if (r_cnt == 5'd1) begin
              o_iscandidate <= (r_sum > w_stage_thr_ext);
              o_haar_sum    <= r_sum;
              o_valid       <= 1'b1;
              o_busy        <= 1'b0;
              r_cnt         <= '0;
              r_state       <= S_DONE;
            end else begin
              r_cnt <= r_cnt + 5'd1;
            end
          end
          S_DONE: r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Capture ROM parameters and integral-image corners one cycle after each address.
  // NOTE: these holding registers are always written before being read, so they
  // carry no reset and can map onto plain flops or distributed RAM.
  always_ff @(posedge clk_fpga) begin
    if (r_state == S_FETCH_PARAM && r_cnt != '0)
      r_param[r_cnt - 5'd1] <= i_rom_data;
    if (r_state == S_FETCH_II && r_cnt != '0)
      r_corner[w_corner_idx] <= i_ii_data;
  end

endmodule

// File: tb/tb_seq_stage_classifier.sv
// Directed bench for seq_stage_classifier: ROM and integral-image models with
// one-cycle read latency, a table of stage runs with hand-computed results,
// and hand-written abort and asynchronous-reset sequences.
module tb_seq_stage_classifier;

  logic        clk_fpga = 1'b0;
  logic        reset_n  = 1'b0;
  logic        i_start  = 1'b0;
  logic        i_abort  = 1'b0;
  logic [11:0] i_stage_base = '0;
  logic [7:0]  i_num_classifiers = '0;
  logic [11:0] o_rom_addr;
  logic [7:0]  i_rom_data;
  logic [7:0]  o_ii_addr;
  logic [15:0] i_ii_data;
  logic        o_busy, o_valid, o_iscandidate;
  logic [15:0] o_haar_sum;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  rom [0:4095];
  logic [15:0] ii  [0:255];

  always #5 clk_fpga = ~clk_fpga;

  // Memory models: data for an address appears one cycle after it is presented.
  always @(posedge clk_fpga) begin
    i_rom_data <= rom[o_rom_addr];
    i_ii_data  <= ii[o_ii_addr];
  end

  seq_stage_classifier dut (
    .clk_fpga          (clk_fpga),
    .reset_n           (reset_n),
    .i_start           (i_start),
    .i_abort           (i_abort),
    .i_stage_base      (i_stage_base),
    .i_num_classifiers (i_num_classifiers),
    .o_rom_addr        (o_rom_addr),
    .i_rom_data        (i_rom_data),
    .o_ii_addr         (o_ii_addr),
    .i_ii_data         (i_ii_data),
    .o_busy            (o_busy),
    .o_valid           (o_valid),
    .o_iscandidate     (o_iscandidate),
    .o_haar_sum        (o_haar_sum)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One classifier record with only rectangle 1 populated.
  task automatic put_cls(input int base, input int c, input logic [7:0] a1, input logic [7:0] b1,
                         input logic [7:0] c1, input logic [7:0] d1, input logic [7:0] w1,
                         input logic [7:0] thr, input logic [7:0] left, input logic [7:0] right);
    int a;
    a = base + c * 18;
    for (int p = 0; p < 18; p++) rom[a + p] = 8'h00;
    rom[a + 0]  = a1;
    rom[a + 1]  = b1;
    rom[a + 2]  = c1;
    rom[a + 3]  = d1;
    rom[a + 4]  = w1;
    rom[a + 15] = thr;
    rom[a + 16] = left;
    rom[a + 17] = right;
  endtask

  // Start a stage and follow it cycle by cycle. Cycle k+1 is the period after
  // edge k, edge 0 being the one that accepts the start.
  task automatic run_case(input string tag, input logic [11:0] base, input logic [7:0] n,
                          input int restart_cyc, input int abort_cyc,
                          input logic [15:0] exp_sum, input logic exp_cand);
    int  got_lat;
    int  exp_lat;
    int  bound;
    bit  busy_ok;
    bit  rom_ok;
    got_lat = -1;
    exp_lat = int'(n) * 33 + 3;
    bound   = int'(n) * 33 + 20;
    busy_ok = 1'b1;
    rom_ok  = 1'b1;
    @(negedge clk_fpga);
    i_stage_base      = base;
    i_num_classifiers = n;
    i_start           = 1'b1;
    @(posedge clk_fpga);
    #1;
    i_start = 1'b0;
    check({tag, "_busy_on_accept"}, 32'(o_busy), 32'd1);
    check({tag, "_cand_cleared"}, 32'(o_iscandidate), 32'd0);
    for (int k = 1; k <= bound; k++) begin
      @(posedge clk_fpga);
      #1;
      if (restart_cyc > 0 && k == restart_cyc - 1) i_start = 1'b1;
      if (restart_cyc > 0 && k == restart_cyc)     i_start = 1'b0;
      if (abort_cyc > 0 && k == abort_cyc - 1)     i_abort = 1'b1;
      if (abort_cyc > 0 && k == abort_cyc) begin
        i_abort = 1'b0;
        check({tag, "_busy_low_after_abort"}, 32'(o_busy), 32'd0);
      end
      if (got_lat >= 0 && k == got_lat)
        check({tag, "_valid_one_cycle"}, 32'(o_valid), 32'd0);
      if (o_valid && got_lat < 0) begin
        got_lat = k + 1;
        check({tag, "_busy_low_with_valid"}, 32'(o_busy), 32'd0);
      end else if (got_lat < 0 && (abort_cyc == 0 || k < abort_cyc) && !o_busy) begin
        busy_ok = 1'b0;
      end
      if (n == 8'd0 && o_rom_addr !== base) rom_ok = 1'b0;
    end
    if (abort_cyc > 0) begin
      check({tag, "_no_valid_after_abort"}, 32'(got_lat), 32'hFFFF_FFFF);
    end else begin
      check({tag, "_latency"}, 32'(got_lat), 32'(exp_lat));
      check({tag, "_busy_held"}, 32'(busy_ok), 32'd1);
    end
    check({tag, "_sum"}, 32'(o_haar_sum), 32'(exp_sum));
    check({tag, "_cand"}, 32'(o_iscandidate), 32'(exp_cand));
    if (n == 8'd0) check({tag, "_single_rom_addr"}, 32'(rom_ok), 32'd1);
  endtask

  typedef struct {
    logic [11:0] base;
    logic [7:0]  n;
    int          restart_cyc;
    logic [15:0] exp_sum;
    logic        exp_cand;
  } vec_t;

  vec_t vecs [5];
  bit   quiet_ok;

  initial begin
    for (int a = 0; a < 4096; a++) rom[a] = 8'h00;
    for (int a = 0; a < 256; a++)  ii[a]  = 16'h0000;
    ii[1] = 16'd100;
    ii[2] = 16'd40;
    ii[3] = 16'd30;
    ii[4] = 16'd10;

    // Stage A: feature 2*40=80 >= THR 50 -> RIGHT 5; 5 > 4.
    put_cls(12'h010, 0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd2, 8'd50, 8'hFD, 8'd5);
    rom[12'h010 + 18] = 8'd4;
    // Stage B: same feature, THR 100 -> LEFT -3; -3 > 4 is false.
    put_cls(12'h040, 0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd2, 8'd100, 8'hFD, 8'd5);
    rom[12'h040 + 18] = 8'd4;
    // Stage C: no classifiers, stage threshold -1; 0 > -1.
    rom[12'h080] = 8'hFF;
    // Stage D: three classifiers, zero features, both leaves 127; 381 > 120.
    for (int c = 0; c < 3; c++) put_cls(12'h100, c, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd127, 8'd127);
    rom[12'h100 + 54] = 8'd120;
    // Stage E: -1*40 + 1*100 + 1*40 = 100, equal to THR -> RIGHT 10; 10 > 10 is false.
    put_cls(12'h180, 0, 8'd1, 8'd2, 8'd3, 8'd4, 8'hFF, 8'd100, 8'hF6, 8'd10);
    rom[12'h180 + 5]  = 8'd1;
    rom[12'h180 + 9]  = 8'd1;
    rom[12'h180 + 10] = 8'd2;
    rom[12'h180 + 14] = 8'd1;
    rom[12'h180 + 18] = 8'd10;
    // Stage F (abort target) stays all-zero at 0x200.

    vecs[0] = '{base: 12'h010, n: 8'd1, restart_cyc: 0,  exp_sum: 16'd5,     exp_cand: 1'b1};
    vecs[1] = '{base: 12'h040, n: 8'd1, restart_cyc: 0,  exp_sum: 16'hFFFD,  exp_cand: 1'b0};
    vecs[2] = '{base: 12'h080, n: 8'd0, restart_cyc: 0,  exp_sum: 16'd0,     exp_cand: 1'b1};
    vecs[3] = '{base: 12'h180, n: 8'd1, restart_cyc: 0,  exp_sum: 16'd10,    exp_cand: 1'b0};
    vecs[4] = '{base: 12'h100, n: 8'd3, restart_cyc: 10, exp_sum: 16'd381,   exp_cand: 1'b1};

    // Reset state, applied with no clock edge needed.
    #12;
    check("reset_busy",  32'(o_busy), 32'd0);
    check("reset_valid", 32'(o_valid), 32'd0);
    check("reset_cand",  32'(o_iscandidate), 32'd0);
    check("reset_sum",   32'(o_haar_sum), 32'd0);
    check("reset_rom_addr", 32'(o_rom_addr), 32'd0);
    check("reset_ii_addr",  32'(o_ii_addr), 32'd0);
    @(negedge clk_fpga);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_fpga);

    for (int i = 0; i < 5; i++)
      run_case($sformatf("vec%0d", i), vecs[i].base, vecs[i].n, vecs[i].restart_cyc, 0,
               vecs[i].exp_sum, vecs[i].exp_cand);

    // Abort during the second classifier: sum keeps the previous 381, candidate was cleared on start.
    run_case("abort", 12'h200, 8'd2, 0, 40, 16'd381, 1'b0);
    run_case("after_abort", 12'h010, 8'd1, 0, 0, 16'd5, 1'b1);

    // Asynchronous reset in the middle of the corner fetch.
    @(negedge clk_fpga);
    i_stage_base      = 12'h010;
    i_num_classifiers = 8'd1;
    i_start           = 1'b1;
    @(posedge clk_fpga);
    #1;
    i_start = 1'b0;
    repeat (24) @(posedge clk_fpga);
    #2;
    check("pre_reset_busy", 32'(o_busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(o_busy), 32'd0);
    check("async_rst_sum",  32'(o_haar_sum), 32'd0);
    check("async_rst_cand", 32'(o_iscandidate), 32'd0);
    check("async_rst_rom_addr", 32'(o_rom_addr), 32'd0);
    check("async_rst_ii_addr",  32'(o_ii_addr), 32'd0);
    @(negedge clk_fpga);
    reset_n  = 1'b1;
    quiet_ok = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk_fpga);
      #1;
      if (o_busy || o_valid || o_rom_addr != 12'd0) quiet_ok = 1'b0;
    end
    check("idle_after_reset", 32'(quiet_ok), 32'd1);
    run_case("after_reset", 12'h040, 8'd1, 0, 0, 16'hFFFD, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
